// File: rtl/bridge_pkg.sv
// Shared definitions for the GPS-to-MCU SPI bridge sequencer: FSM states and
// bridge timing constants that fix the default frame length.
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int unsigned BRIDGE_SLOT_CYCLES    = 4;
    localparam int unsigned BRIDGE_CNT_BITS       = 13;
    localparam int unsigned NIBBLES_PER_FRAME_DEF = (1 << BRIDGE_CNT_BITS) / BRIDGE_SLOT_CYCLES;

endpackage

// File: rtl/bridge_drop_cnt.sv
// Saturating lost-sample counter with sticky overrun flag; a clear coincident
// with a drop restarts the count at one.
module bridge_drop_cnt #(
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              drop,
    input  logic              clr,
    output logic              overrun,
    output logic [DROP_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
            count   <= '0;
        end else if (clr) begin
            overrun <= drop;
            count   <= drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (count != '1) begin
                count <= count + DROP_W'(1);
            end
        end
    end

endmodule

// File: rtl/bridge_frame_ctrl.sv
// Paces DATAREADY pulses into the SPI bridge's 4-cycle slot, bounds frames to
// the bridge bit-counter wrap, buffers one sample and latches self-test per frame.
module bridge_frame_ctrl
    import bridge_pkg::*;
#(
    parameter int unsigned NIBBLES_PER_FRAME = NIBBLES_PER_FRAME_DEF,
    parameter int unsigned GAP_CYCLES        = 4,
    parameter int unsigned DROP_W            = 8
) (
    input  logic              MCU_CLK_25_000,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              SELF_TEST_REQ,
    input  logic              SAMPLE_VALID,
    input  logic              CLR_OVERRUN,
    output logic              DATAREADY,
    output logic              SELF_TEST,
    output logic              FRAME_ACTIVE,
    output logic              FRAME_DONE,
    output logic              OVERRUN,
    output logic [DROP_W-1:0] DROP_COUNT
);

    localparam int unsigned       NIB_W     = $clog2(NIBBLES_PER_FRAME + 1);
    localparam int unsigned       GAP_W     = $clog2(GAP_CYCLES);
    localparam logic [NIB_W-1:0]  NIB_LAST  = NIB_W'(NIBBLES_PER_FRAME);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [1:0]        SLOT_LOAD = 2'(BRIDGE_SLOT_CYCLES - 1);

    state_t             state, state_n;
    logic [1:0]         slot, slot_n;
    logic               pending, pending_n;
    logic [NIB_W-1:0]   nib_cnt, nib_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic               self_test_n;
    logic               issue;
    logic               drop;

    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_IDLE;
            slot         <= '0;
            pending      <= 1'b0;
            nib_cnt      <= '0;
            gap_cnt      <= '0;
            DATAREADY    <= 1'b0;
            SELF_TEST    <= 1'b0;
            FRAME_ACTIVE <= 1'b0;
            FRAME_DONE   <= 1'b0;
        end else begin
            state        <= state_n;
            slot         <= slot_n;
            pending      <= pending_n;
            nib_cnt      <= nib_n;
            gap_cnt      <= gap_n;
            DATAREADY    <= issue;
            SELF_TEST    <= self_test_n;
            FRAME_ACTIVE <= (state_n == ST_XFER);
            FRAME_DONE   <= (state == ST_XFER) && (state_n == ST_GAP);
        end
    end

    always_comb begin
        state_n     = state;
        slot_n      = (slot == '0) ? '0 : slot - 2'd1;
        pending_n   = pending;
        nib_n       = nib_cnt;
        gap_n       = gap_cnt;
        self_test_n = SELF_TEST;
        issue       = 1'b0;
        drop        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (ENABLE) begin
                    state_n     = ST_XFER;
                    self_test_n = SELF_TEST_REQ;
                    nib_n       = '0;
                end
            end
            ST_XFER: begin
                // Frame closes only once the last nibble's slot has drained.
                if (slot == '0) begin
                    if (nib_cnt == NIB_LAST) begin
                        state_n = ST_GAP;
                        gap_n   = GAP_LOAD;
                    end else begin
                        issue = SELF_TEST | pending | SAMPLE_VALID;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    if (ENABLE) begin
                        state_n     = ST_XFER;
                        self_test_n = SELF_TEST_REQ;
                        nib_n       = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    gap_n = gap_cnt - GAP_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (issue) begin
            slot_n = SLOT_LOAD;
            nib_n  = nib_cnt + NIB_W'(1);
        end

        if (SELF_TEST) begin
            pending_n = 1'b0;
        end else if (state != ST_IDLE) begin
            if (issue) begin
                pending_n = pending & SAMPLE_VALID;
            end else if (SAMPLE_VALID) begin
                drop      = pending;
                pending_n = 1'b1;
            end
        end

        if (state_n == ST_IDLE) begin
            pending_n = 1'b0;
        end else if ((state != ST_XFER) && (state_n == ST_XFER) && self_test_n) begin
            pending_n = 1'b0;
        end
    end

    bridge_drop_cnt #(
        .DROP_W (DROP_W)
    ) u_drop_cnt (
        .clk     (MCU_CLK_25_000),
        .rst_n   (RESET_N),
        .drop    (drop),
        .clr     (CLR_OVERRUN),
        .overrun (OVERRUN),
        .count   (DROP_COUNT)
    );

endmodule
